// File: rtl/four_bit_decade_pkg.sv
// Shared constants for the decade counter: digit width, terminal value
// and the active-high {g,f,e,d,c,b,a} seven-segment table.
`timescale 1ns/1ps
package four_bit_decade_pkg;

  localparam int DIGIT_W = 4;
  localparam int SEG_W   = 7;

  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/four_bit_decade_bcd_to_7seg.sv
// Combinational BCD digit to seven-segment decoder; non-BCD codes blank
// the display.
`timescale 1ns/1ps
module bcd_to_7seg
  import four_bit_decade_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/four_bit_decade.sv
// Mod-10 up-counter with async active-high reset, terminal-count flag
// and seven-segment decode of the current digit.
`timescale 1ns/1ps
module four_bit_decade
  import four_bit_decade_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  output logic [DIGIT_W-1:0] out,
  output logic               tc,
  output logic [SEG_W-1:0]   seg
);

  // Wrap at 9 and also recover from any 10..15 upset in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out <= '0;
    else if (out >= DIGIT_MAX)
      out <= '0;
    else
      out <= out + 4'd1;
  end

  assign tc = (out == DIGIT_MAX);

  bcd_to_7seg u_seg (
    .digit (out),
    .seg   (seg)
  );

endmodule

// File: tb/tb_four_bit_decade.sv
// Self-checking bench for four_bit_decade against a modulo-10 reference
// with randomized run lengths and reset instants.
`timescale 1ns/1ps
module tb_four_bit_decade;

  logic       clk = 1'b1;
  logic       rst = 1'b1;
  logic [3:0] out;
  logic       tc;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;
  int model  = 0;

  four_bit_decade dut (
    .clk (clk),
    .rst (rst),
    .out (out),
    .tc  (tc),
    .seg (seg)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic int seg_ref(input int v);
    case (v)
      0: return 'h3F;
      1: return 'h06;
      2: return 'h5B;
      3: return 'h4F;
      4: return 'h66;
      5: return 'h6D;
      6: return 'h7D;
      7: return 'h07;
      8: return 'h7F;
      9: return 'h6F;
      default: return 'h00;
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".out"}, int'(out), model);
    check({tag, ".tc"},  int'(tc),  (model == 9) ? 1 : 0);
    check({tag, ".seg"}, int'(seg), seg_ref(model));
  endtask

  // One clock edge of the reference: reset forces 0, otherwise (n+1) mod 10,
  // and anything outside 0..9 returns to 0.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst)             model = 0;
    else if (model >= 9) model = 0;
    else                 model = model + 1;
    check_outputs("step");
    if ($time == 201)  check("t200.out", int'(out), 1);
    if ($time == 1001) check("t1000.out", int'(out), 9);
  endtask

  initial begin
    int zeros, tc_high, tc_rise;
    logic tc_prev;

    // Reset hold across the first edge.
    #25  check_outputs("rst_hold0");
    #50  check_outputs("rst_hold1");
    #50  check_outputs("rst_hold2");
    #25  rst = 1'b0;

    zeros = 0; tc_high = 0; tc_rise = 0; tc_prev = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (out == 4'd0) zeros++;
      if (tc) tc_high++;
      if (tc && !tc_prev) tc_rise++;
      tc_prev = tc;
    end
    check("period.zeros",   zeros,   3);
    check("period.tc_high", tc_high, 3);
    check("period.tc_rise", tc_rise, 3);

    repeat ($urandom_range(0, 9)) step();
    for (int i = 0; i < 10 && out != 4'd6; i++) step();
    check("reach6.out", int'(out), 6);

    // Async reset between edges, then resume from 0.
    @(negedge clk);
    #10 rst = 1'b1;
    #1  model = 0;
    check_outputs("async_rst");
    step();
    @(negedge clk) rst = 1'b0;
    step();
    check("resume.out", int'(out), 1);

    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(1, 12)) step();
      @(negedge clk);
      #($urandom_range(1, 40)) rst = 1'b1;
      #1 model = 0;
      check_outputs("rand_rst");
      step();
      @(negedge clk) rst = 1'b0;
      step();
    end

    // Illegal-state recovery from injected out-of-range values.
    @(negedge clk);
    force dut.out = 4'd12;
    #1 model = 12;
    check_outputs("ill12");
    #5 release dut.out;
    step();
    check("ill12.recover", int'(out), 0);
    step();

    @(negedge clk);
    force dut.out = 4'd15;
    #1 model = 15;
    check_outputs("ill15");
    #5 release dut.out;
    step();
    check("ill15.recover", int'(seg), 'h3F);

    repeat ($urandom_range(5, 15)) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
